// File: rtl/spi_tx_serializer_if.sv
// Word-input handshake bundle for spi_tx_serializer.
// The producer drives in_data/in_valid; the serializer answers with in_ready.
interface spi_tx_serializer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/spi_tx_serializer.sv
// SPI-style output stage: takes parallel words over valid/ready, buffers one
// word, and shifts it out with an enable line and a generated bit clock.
// Line coding is Manchester (bit then ~bit) or NRZ, bit order selectable.
// All line outputs are registered and derived from next-state values, so the
// first half-cell appears one edge after the hold register fills.
module spi_tx_serializer #(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 1,
   parameter int MSB_FIRST  = 0,
   parameter int MANCHESTER = 1
) (
   input  logic                clk,
   input  logic                rst,
   spi_tx_serializer_if.slave  in_if,
   output logic                out,
   output logic                en_out,
   output logic                clk_out,
   output logic                done,
   output logic                busy
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Advance the shifter by one bit in the configured direction.
   function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
      if (MSB_FIRST != 0) begin
         return {v[DATA_W-2:0], 1'b0};
      end else begin
         return {1'b0, v[DATA_W-1:1]};
      end
   endfunction

   state_t            state_r, state_s;
   logic [DATA_W-1:0] hold_data_r;
   logic              hold_full_r;
   logic [DATA_W-1:0] shift_r, shift_s;
   logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
   logic              half_r, half_s;
   logic [DIV_W-1:0]  div_cnt_r, div_cnt_s;
   logic              done_s;
   logic              load_s;
   logic              accept_s;
   logic              cur_bit_s;
   logic              en_s;
   logic              clk_s;
   logic              out_s;
   logic              out_r, en_r, clk_r, done_r;

   // Holding buffer is free whenever it is empty and reset is released.
   assign in_if.in_ready = ~hold_full_r & ~rst;
   assign accept_s       = in_if.in_valid & ~hold_full_r & ~rst;

   // Holding register: capture on handshake, release when the shifter loads it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_data_r <= {DATA_W{1'b0}};
         hold_full_r <= 1'b0;
      end else if (accept_s) begin
         hold_data_r <= in_if.in_data;
         hold_full_r <= 1'b1;
      end else if (load_s) begin
         hold_full_r <= 1'b0;
      end
   end

   // Next-state logic for the FSM, shifter, bit/half counters and line outputs.
   always_comb begin
      state_s   = state_r;
      shift_s   = shift_r;
      bit_cnt_s = bit_cnt_r;
      half_s    = half_r;
      div_cnt_s = div_cnt_r;
      done_s    = 1'b0;
      load_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (hold_full_r) begin
               load_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (div_cnt_r == LAST_DIV) begin
               div_cnt_s = {DIV_W{1'b0}};
               if (!half_r) begin
                  half_s = 1'b1;
               end else begin
                  half_s = 1'b0;
                  if (bit_cnt_r == LAST_BIT) begin
                     // Last half-cell of the word ends here.
                     done_s    = 1'b1;
                     bit_cnt_s = {CNT_W{1'b0}};
                     if (hold_full_r) begin
                        load_s = 1'b1;
                     end else begin
                        state_s = ST_IDLE;
                        shift_s = {DATA_W{1'b0}};
                     end
                  end else begin
                     bit_cnt_s = bit_cnt_r + CNT_W'(1);
                     shift_s   = shift_next(shift_r);
                  end
               end
            end else begin
               div_cnt_s = div_cnt_r + DIV_W'(1);
            end
         end
         default: begin
            state_s   = ST_IDLE;
            shift_s   = {DATA_W{1'b0}};
            bit_cnt_s = {CNT_W{1'b0}};
            half_s    = 1'b0;
            div_cnt_s = {DIV_W{1'b0}};
         end
      endcase

      // A load (from idle or back-to-back at word end) restarts the shifter.
      if (load_s) begin
         state_s   = ST_SHIFT;
         shift_s   = hold_data_r;
         bit_cnt_s = {CNT_W{1'b0}};
         half_s    = 1'b0;
         div_cnt_s = {DIV_W{1'b0}};
      end else begin
         load_s = 1'b0;
      end

      // Line values for the cycle that follows this edge.
      en_s      = (state_s == ST_SHIFT);
      cur_bit_s = (MSB_FIRST != 0) ? shift_s[DATA_W-1] : shift_s[0];
      clk_s     = en_s & half_s;
      out_s     = en_s & ((MANCHESTER != 0) ? (cur_bit_s ^ half_s) : cur_bit_s);
   end

   // FSM, shifter and counter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         shift_r   <= {DATA_W{1'b0}};
         bit_cnt_r <= {CNT_W{1'b0}};
         half_r    <= 1'b0;
         div_cnt_r <= {DIV_W{1'b0}};
      end else begin
         state_r   <= state_s;
         shift_r   <= shift_s;
         bit_cnt_r <= bit_cnt_s;
         half_r    <= half_s;
         div_cnt_r <= div_cnt_s;
      end
   end

   // Registered line outputs so out/en_out/clk_out/done never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r  <= 1'b0;
         en_r   <= 1'b0;
         clk_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         out_r  <= out_s;
         en_r   <= en_s;
         clk_r  <= clk_s;
         done_r <= done_s;
      end
   end

   assign out     = out_r;
   assign en_out  = en_r;
   assign clk_out = clk_r;
   assign done    = done_r;
   assign busy    = en_r;

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Self-checking bench for spi_tx_serializer. Three instances cover
// Manchester LSB-first (8b, div 1), NRZ MSB-first (8b, div 2) and
// Manchester MSB-first (12b, div 3). A queue scoreboard expands every
// accepted word into per-cycle line values and compares them each cycle.
module tb_spi_tx_serializer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   spi_tx_serializer_if #(.DATA_W(8))  if0 ();
   spi_tx_serializer_if #(.DATA_W(8))  if1 ();
   spi_tx_serializer_if #(.DATA_W(12)) if2 ();

   logic [2:0]  s_out, s_en, s_clk, s_done, s_busy;
   logic [2:0]  s_valid, s_ready;
   logic [11:0] s_data [3];

   spi_tx_serializer #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0), .MANCHESTER(1)) u0 (
      .clk(clk), .rst(rst), .in_if(if0), .out(s_out[0]), .en_out(s_en[0]),
      .clk_out(s_clk[0]), .done(s_done[0]), .busy(s_busy[0]));
   spi_tx_serializer #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1), .MANCHESTER(0)) u1 (
      .clk(clk), .rst(rst), .in_if(if1), .out(s_out[1]), .en_out(s_en[1]),
      .clk_out(s_clk[1]), .done(s_done[1]), .busy(s_busy[1]));
   spi_tx_serializer #(.DATA_W(12), .CLK_DIV(3), .MSB_FIRST(1), .MANCHESTER(1)) u2 (
      .clk(clk), .rst(rst), .in_if(if2), .out(s_out[2]), .en_out(s_en[2]),
      .clk_out(s_clk[2]), .done(s_done[2]), .busy(s_busy[2]));

   assign s_valid   = {if2.in_valid, if1.in_valid, if0.in_valid};
   assign s_ready   = {if2.in_ready, if1.in_ready, if0.in_ready};
   assign s_data[0] = {4'h0, if0.in_data};
   assign s_data[1] = {4'h0, if1.in_data};
   assign s_data[2] = if2.in_data;

   // Scoreboard: wq holds accepted words awaiting the shifter; line_q holds
   // {last, out, clk_out} for each remaining cycle of the word on the line.
   logic [11:0] wq     [3][$];
   logic [2:0]  line_q [3][$];
   logic [2:0]  done_exp = 3'b000;
   int          acc_cnt [3];
   int          en_cnt  [3];
   int          done_cnt[3];
   logic [31:0] cap     [3];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic int cfg_dw(input int d);
      case (d)
         2:       return 12;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_div(input int d);
      case (d)
         0:       return 1;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic cfg_msb(input int d);
      return (d != 0);
   endfunction

   function automatic logic cfg_man(input int d);
      return (d != 1);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Expand one word into per-cycle expected line values.
   task automatic load_word(input int d, input logic [11:0] w);
      int   dw;
      int   idx;
      logic bv;
      logic lv;
      logic ov;
      dw = cfg_dw(d);
      for (int b = 0; b < dw; b++) begin
         idx = cfg_msb(d) ? (dw - 1 - b) : b;
         bv  = w[idx];
         for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < cfg_div(d); c++) begin
               lv = (b == dw - 1) && (h == 1) && (c == cfg_div(d) - 1);
               ov = cfg_man(d) ? (bv ^ h[0]) : bv;
               line_q[d].push_back({lv, ov, h[0]});
            end
         end
      end
   endtask

   task automatic model_step(input int d);
      logic       acc;
      logic [2:0] it;
      acc = s_valid[d] && (wq[d].size() == 0);
      done_exp[d] = 1'b0;
      if (line_q[d].size() > 0) begin
         it = line_q[d].pop_front();
         done_exp[d] = it[2];
      end
      if ((line_q[d].size() == 0) && (wq[d].size() > 0)) begin
         load_word(d, wq[d].pop_front());
      end
      if (acc) begin
         wq[d].push_back(s_data[d]);
         acc_cnt[d]++;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         wq[d].delete();
         line_q[d].delete();
         done_exp[d] = 1'b0;
      end
   endtask

   task automatic check_dut(input int d);
      logic [5:0] act;
      logic [5:0] exp;
      logic [2:0] it;
      logic       e_en;
      act = {s_en[d], s_out[d], s_clk[d], s_done[d], s_busy[d], s_ready[d]};
      if (rst) begin
         exp = 6'b000000;
      end else begin
         e_en = (line_q[d].size() > 0);
         it   = e_en ? line_q[d][0] : 3'b000;
         exp  = {e_en, it[1], it[0], done_exp[d], e_en, (wq[d].size() == 0)};
      end
      check_val($sformatf("line%0d{en,out,clk,done,busy,rdy}", d), 32'(act), 32'(exp));
      if (s_en[d]) begin
         en_cnt[d]++;
         cap[d] = {cap[d][30:0], s_out[d]};
      end
      if (s_done[d]) begin
         done_cnt[d]++;
      end
   endtask

   // Reference model advances on the same edges as the DUT.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         for (int d = 0; d < 3; d++) model_step(d);
      end
   end

   // Compare every DUT output against the scoreboard away from the active edge.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) check_dut(d);
   end

   task automatic set_in(input int d, input logic v, input logic [11:0] w);
      case (d)
         0: begin if0.in_valid = v; if0.in_data = w[7:0]; end
         1: begin if1.in_valid = v; if1.in_data = w[7:0]; end
         default: begin if2.in_valid = v; if2.in_data = w; end
      endcase
   endtask

   task automatic clr_stats(input int d);
      en_cnt[d]   = 0;
      done_cnt[d] = 0;
      cap[d]      = 32'h0;
   endtask

   task automatic send(input int d, input logic [11:0] w);
      int n;
      n = 0;
      @(negedge clk);
      while ((wq[d].size() != 0) && (n < 500)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check_val("send_timeout", 32'd0, 32'd1);
      set_in(d, 1'b1, w);
      @(negedge clk);
      set_in(d, 1'b0, 12'h000);
   endtask

   task automatic wait_acc(input int d, input int target);
      int n;
      n = 0;
      while ((acc_cnt[d] < target) && (n < 500)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check_val("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while (((line_q[d].size() != 0) || (wq[d].size() != 0)) && (n < 2000)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check_val("idle_timeout", 32'd0, 32'd1);
      @(negedge clk);
      @(negedge clk);
   endtask

   int base;

   initial begin
      for (int d = 0; d < 3; d++) begin
         acc_cnt[d] = 0;
         clr_stats(d);
      end
      rst = 1'b1;
      set_in(0, 1'b0, 12'h000);
      set_in(1, 1'b0, 12'h000);
      set_in(2, 1'b0, 12'h000);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #1 check_val("rdy_after_init", 32'(s_ready), 32'h7);

      // Manchester LSB-first, 0xA5
      clr_stats(0);
      send(0, 12'h0A5);
      wait_idle(0);
      check_val("t1_en_len", en_cnt[0], 32'd16);
      check_val("t1_done_cnt", done_cnt[0], 32'd1);
      check_val("t1_wave", 32'(cap[0][15:0]), 32'h9966);

      // NRZ MSB-first, divider 2, 0x3C
      clr_stats(1);
      send(1, 12'h03C);
      wait_idle(1);
      check_val("t2_en_len", en_cnt[1], 32'd32);
      check_val("t2_done_cnt", done_cnt[1], 32'd1);
      check_val("t2_wave", cap[1], 32'h00FFFF00);

      // Back-to-back with in_valid held, then backpressure with data toggling
      clr_stats(0);
      @(negedge clk);
      base = acc_cnt[0];
      set_in(0, 1'b1, 12'h001);
      wait_acc(0, base + 1);
      set_in(0, 1'b1, 12'h080);
      wait_acc(0, base + 2);
      for (int i = 0; i < 8; i++) begin
         set_in(0, 1'b1, (i % 2 == 1) ? 12'h055 : 12'h0AA);
         @(negedge clk);
      end
      set_in(0, 1'b0, 12'h000);
      wait_idle(0);
      check_val("t3_en_len", en_cnt[0], 32'd32);
      check_val("t3_done_cnt", done_cnt[0], 32'd2);
      check_val("t3_wave", cap[0], 32'h95555556);

      // Reset during bit 3 of a word
      clr_stats(0);
      send(0, 12'h05A);
      repeat (7) @(negedge clk);
      check_val("t4_mid_word_en", 32'(s_en[0]), 32'd1);
      #2 rst = 1'b1;
      #1 check_val("t4_async_clear", 32'({s_out[0], s_en[0], s_clk[0], s_done[0], s_busy[0]}), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_val("t4_rdy_after_rst", 32'(s_ready), 32'h7);
      check_val("t4_no_done", done_cnt[0], 32'd0);
      clr_stats(0);
      send(0, 12'h0FF);
      wait_idle(0);
      check_val("t4_en_len", en_cnt[0], 32'd16);
      check_val("t4_done_cnt", done_cnt[0], 32'd1);
      check_val("t4_wave", 32'(cap[0][15:0]), 32'hAAAA);

      // 12-bit word, divider 3
      clr_stats(2);
      send(2, 12'hABC);
      wait_idle(2);
      check_val("t5_en_len", en_cnt[2], 32'd72);
      check_val("t5_done_cnt", done_cnt[2], 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
